// File: rtl/sha_pkg.sv
// Shared constants and state encoding for the SHA-256 message front end.
package sha_pkg;

  localparam int BLOCK_BYTES = 64;
  localparam int BLOCK_SHIFT = 6;
  localparam int LEN_BYTES   = 8;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    SEND,
    GAP
  } state_t;

endpackage

// File: rtl/sha_byte_fifo.sv
// Synchronous byte FIFO with show-ahead read data and an occupancy count.
module sha_byte_fifo #(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    pop_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count    = wr_ptr - rd_ptr;
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/sha_msg_sequencer.sv
// Pads a byte stream into SHA-256 blocks and feeds them to the core
// as unbroken 64-byte bursts with first/last block flags.
module sha_msg_sequencer
  import sha_pkg::*;
#(
  parameter int LEN_W      = 32,
  parameter int FIFO_DEPTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_ready,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic [7:0]       core_data,
  output logic             core_write_enable,
  output logic             core_first_block,
  output logic             core_last_block,
  input  logic             core_busy,
  input  logic             core_output_valid,
  output logic             msg_done,
  output logic             active
);

  localparam int CW  = LEN_W + 4;
  localparam int FAW = $clog2(FIFO_DEPTH);

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] accepted;
  logic [CW-1:0]    pos;
  logic [CW-1:0]    total_q;
  logic [6:0]       byte_cnt;
  logic             ov_q;

  logic [CW-1:0]    len_ext;
  logic [CW-1:0]    total_calc;
  logic [CW-1:0]    remaining;
  logic [CW-1:0]    need;
  logic [CW-1:0]    tail_start;
  logic [63:0]      bit_len;
  logic [7:0]       stream_byte;
  logic             is_msg;
  logic             launch_ok;
  logic             last_blk;
  logic             emit_now;

  logic             push;
  logic             pop;
  logic [7:0]       fifo_data;
  logic [FAW:0]     fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  sha_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .pop_data  (fifo_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Total stream length is a whole number of blocks with room for 0x80 and the length field.
  assign total_calc = (((CW'(cmd_len) + CW'(LEN_BYTES)) >> BLOCK_SHIFT) + CW'(1)) << BLOCK_SHIFT;
  assign len_ext    = CW'(len_q);
  assign remaining  = (len_ext > pos) ? (len_ext - pos) : '0;
  assign need       = (remaining > CW'(BLOCK_BYTES)) ? CW'(BLOCK_BYTES) : remaining;
  assign launch_ok  = (CW'(fifo_count) >= need) && !core_busy;
  assign last_blk   = ((pos + CW'(BLOCK_BYTES)) == total_q);
  assign tail_start = total_q - CW'(LEN_BYTES);
  assign bit_len    = 64'({len_q, 3'b000});
  assign is_msg     = (pos < len_ext);

  assign emit_now  = ((state == LAUNCH) && launch_ok) ||
                     ((state == SEND) && (byte_cnt != 7'(BLOCK_BYTES)));
  assign pop       = emit_now && is_msg && !fifo_empty;
  assign push      = in_valid && in_ready;
  assign in_ready  = !fifo_full && (accepted < len_q);
  assign cmd_ready = reset && (state == IDLE);
  assign msg_done  = ov_q && !core_output_valid;

  always_comb begin
    stream_byte = 8'h00;
    if (is_msg)
      stream_byte = fifo_data;
    else if (pos == len_ext)
      stream_byte = PAD_BYTE;
    else if (pos >= tail_start)
      stream_byte = 8'(bit_len >> {3'd7 - pos[2:0], 3'b000});
  end

  // Outputs are registered: the cycle that decides to send a byte also loads it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      len_q             <= '0;
      accepted          <= '0;
      pos               <= '0;
      total_q           <= '0;
      byte_cnt          <= '0;
      ov_q              <= 1'b0;
      core_data         <= 8'h00;
      core_write_enable <= 1'b0;
      core_first_block  <= 1'b0;
      core_last_block   <= 1'b0;
      active            <= 1'b0;
    end else begin
      ov_q <= core_output_valid;
      if (push) accepted <= accepted + LEN_W'(1);
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            len_q    <= cmd_len;
            total_q  <= total_calc;
            accepted <= '0;
            pos      <= '0;
            active   <= 1'b1;
            state    <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (launch_ok) begin
            core_data         <= stream_byte;
            core_write_enable <= 1'b1;
            core_first_block  <= (pos == '0);
            core_last_block   <= last_blk;
            pos               <= pos + CW'(1);
            byte_cnt          <= 7'd1;
            state             <= SEND;
          end
        end
        SEND: begin
          core_first_block <= 1'b0;
          core_last_block  <= 1'b0;
          if (byte_cnt == 7'(BLOCK_BYTES)) begin
            core_data         <= 8'h00;
            core_write_enable <= 1'b0;
            if (pos == total_q) begin
              active <= 1'b0;
              state  <= IDLE;
            end else begin
              state  <= GAP;
            end
          end else begin
            core_data <= stream_byte;
            pos       <= pos + CW'(1);
            byte_cnt  <= byte_cnt + 7'd1;
          end
        end
        GAP: state <= LAUNCH;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_msg_sequencer.sv
// Directed bench for the SHA-256 message sequencer: padding, flags, spacing, reset.
module tb_sha_msg_sequencer;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic [31:0] cmd_len;
  logic        cmd_ready;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [7:0]  core_data;
  logic        core_write_enable;
  logic        core_first_block;
  logic        core_last_block;
  logic        core_busy;
  logic        core_output_valid;
  logic        msg_done;
  logic        active;

  int checks = 0;
  int errors = 0;

  logic        mon_clear = 1'b0;
  logic [7:0]  cap_data  [0:1023];
  bit          cap_first [0:1023];
  bit          cap_last  [0:1023];
  int          cap_cnt = 0;
  int          runs [0:15];
  int          gaps [0:15];
  int          run_cnt = 0;
  int          run_len = 0;
  int          gap_len = 0;
  bit          seen_run = 1'b0;
  int          viol = 0;
  int          done_cnt = 0;

  sha_msg_sequencer #(.LEN_W(32), .FIFO_DEPTH(64)) dut (
    .clk               (clk),
    .reset             (reset),
    .cmd_valid         (cmd_valid),
    .cmd_len           (cmd_len),
    .cmd_ready         (cmd_ready),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_ready          (in_ready),
    .core_data         (core_data),
    .core_write_enable (core_write_enable),
    .core_first_block  (core_first_block),
    .core_last_block   (core_last_block),
    .core_busy         (core_busy),
    .core_output_valid (core_output_valid),
    .msg_done          (msg_done),
    .active            (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records the byte stream, burst lengths, idle gaps and idle-cycle output leaks.
  always @(negedge clk) begin
    if (mon_clear) begin
      cap_cnt  <= 0;
      run_cnt  <= 0;
      run_len  <= 0;
      gap_len  <= 0;
      seen_run <= 1'b0;
      viol     <= 0;
      done_cnt <= 0;
    end else begin
      if (msg_done) done_cnt <= done_cnt + 1;
      if (core_write_enable) begin
        if (cap_cnt < 1024) begin
          cap_data[cap_cnt]  <= core_data;
          cap_first[cap_cnt] <= core_first_block;
          cap_last[cap_cnt]  <= core_last_block;
        end
        cap_cnt <= cap_cnt + 1;
        if (run_len == 0 && seen_run && run_cnt < 16) gaps[run_cnt] <= gap_len;
        run_len <= run_len + 1;
      end else begin
        if (core_data != 8'h00 || core_first_block || core_last_block) viol <= viol + 1;
        if (run_len != 0) begin
          if (run_cnt < 16) runs[run_cnt] <= run_len;
          run_cnt  <= run_cnt + 1;
          run_len  <= 0;
          seen_run <= 1'b1;
          gap_len  <= 1;
        end else begin
          gap_len <= gap_len + 1;
        end
      end
    end
  end

  function automatic logic [7:0] msg_byte(input int mode, input int i);
    if (mode == 0) return 8'h30;
    return 8'((i * 7 + 3) & 255);
  endfunction

  function automatic logic [7:0] exp_byte(input int len, input int mode, input int i);
    int nb = (len + 8) / 64 + 1;
    int total = nb * 64;
    longint unsigned bl = longint'(len) * 8;
    if (i < len) return msg_byte(mode, i);
    if (i == len) return 8'h80;
    if (i >= total - 8) return 8'(bl >> (8 * (total - 1 - i)));
    return 8'h00;
  endfunction

  function automatic int stream_errs(input int len, input int mode);
    int nb = (len + 8) / 64 + 1;
    int n = 0;
    for (int i = 0; i < nb * 64 && i < 1024; i++)
      if (cap_data[i] !== exp_byte(len, mode, i)) n++;
    return n;
  endfunction

  function automatic int flag_errs(input int nb);
    int n = 0;
    for (int i = 0; i < cap_cnt && i < 1024; i++) begin
      if (cap_first[i] !== (i == 0)) n++;
      if (cap_last[i] !== (i == (nb - 1) * 64)) n++;
    end
    return n;
  endfunction

  function automatic int run_errs();
    int n = 0;
    for (int r = 0; r < run_cnt && r < 16; r++)
      if (runs[r] != 64) n++;
    return n;
  endfunction

  task automatic clear_mon();
    @(posedge clk); #1 mon_clear = 1'b1;
    @(posedge clk); #1 mon_clear = 1'b0;
  endtask

  task automatic issue_cmd(input int len);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_len   = len;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_len   = '0;
  endtask

  task automatic feed(input int len, input int mode, input bit toggle);
    int idx = 0;
    int cyc = 0;
    while (idx < len && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (in_ready && (!toggle || (cyc % 2 == 0))) begin
        in_valid = 1'b1;
        in_data  = msg_byte(mode, idx);
        idx++;
      end else begin
        in_valid = 1'b0;
        in_data  = 8'h00;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h00;
    if (idx < len) begin
      errors++;
      $display("[TB] FAIL feed_timeout: accepted %0d bytes, required %0d", idx, len);
    end
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while (active && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (active !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_timeout: active %b, required 0", active);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic stall_core();
    bit saw_we = 1'b0;
    int cyc = 0;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (core_write_enable) saw_we = 1'b1;
      else if (saw_we) break;
    end
    core_busy = 1'b1;
    repeat (10) @(negedge clk);
    core_busy = 1'b0;
  endtask

  task automatic drop_digest();
    repeat (20) @(negedge clk);
    @(posedge clk);
    #2 core_output_valid = 1'b0;
  endtask

  task automatic run_msg(input int len, input int mode, input bit toggle,
                         input bit stall, input bit drop_cov);
    clear_mon();
    issue_cmd(len);
    fork
      feed(len, mode, toggle);
      if (stall) stall_core();
      if (drop_cov) drop_digest();
    join
    wait_idle();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready, in_ready, core_write_enable, active, msg_done} !== 5'b0 || core_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_outputs: cmd_ready %b we %b active %b data %h, required all 0",
               cmd_ready, core_write_enable, active, core_data);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || in_ready !== 1'b0 || active !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release: cmd_ready %b in_ready %b active %b, required 1 0 0",
               cmd_ready, in_ready, active);
    end
  endtask

  task automatic test_two_block();
    run_msg(56, 0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (cap_cnt !== 128 || run_cnt !== 2 || run_errs() !== 0) begin
      errors++;
      $display("[TB] FAIL two_block_shape: bytes %0d runs %0d bad_runs %0d, required 128 2 0",
               cap_cnt, run_cnt, run_errs());
    end
    checks++;
    if (gaps[1] !== 2) begin
      errors++;
      $display("[TB] FAIL two_block_gap: got %0d idle cycles, required 2", gaps[1]);
    end
    checks++;
    if (cap_data[56] !== 8'h80 || cap_data[125] !== 8'h00 || cap_data[126] !== 8'h01 || cap_data[127] !== 8'hC0) begin
      errors++;
      $display("[TB] FAIL two_block_pad: b56 %h b126 %h b127 %h, required 80 01 C0",
               cap_data[56], cap_data[126], cap_data[127]);
    end
    checks++;
    if (stream_errs(56, 0) !== 0 || flag_errs(2) !== 0 || viol !== 0 || done_cnt !== 0) begin
      errors++;
      $display("[TB] FAIL two_block_stream: byte_errs %0d flag_errs %0d leaks %0d done %0d, required 0",
               stream_errs(56, 0), flag_errs(2), viol, done_cnt);
    end
    core_output_valid = 1'b1;
  endtask

  task automatic test_overlap();
    run_msg(120, 0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (cap_cnt !== 192 || run_cnt !== 3 || run_errs() !== 0 || gaps[1] !== 2 || gaps[2] !== 2) begin
      errors++;
      $display("[TB] FAIL overlap_shape: bytes %0d runs %0d gaps %0d %0d, required 192 3 2 2",
               cap_cnt, run_cnt, gaps[1], gaps[2]);
    end
    checks++;
    if (cap_data[120] !== 8'h80 || cap_data[190] !== 8'h03 || cap_data[191] !== 8'hC0) begin
      errors++;
      $display("[TB] FAIL overlap_pad: b120 %h b190 %h b191 %h, required 80 03 C0",
               cap_data[120], cap_data[190], cap_data[191]);
    end
    checks++;
    if (stream_errs(120, 0) !== 0 || flag_errs(3) !== 0 || viol !== 0) begin
      errors++;
      $display("[TB] FAIL overlap_stream: byte_errs %0d flag_errs %0d leaks %0d, required 0",
               stream_errs(120, 0), flag_errs(3), viol);
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("[TB] FAIL msg_done_pulse: got %0d pulses, required 1", done_cnt);
    end
  endtask

  task automatic test_empty();
    run_msg(0, 0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (cap_cnt !== 64 || cap_data[0] !== 8'h80 || cap_first[0] !== 1'b1 || cap_last[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL empty_block: bytes %0d b0 %h first %b last %b, required 64 80 1 1",
               cap_cnt, cap_data[0], cap_first[0], cap_last[0]);
    end
    checks++;
    if (stream_errs(0, 0) !== 0 || flag_errs(1) !== 0) begin
      errors++;
      $display("[TB] FAIL empty_stream: byte_errs %0d flag_errs %0d, required 0",
               stream_errs(0, 0), flag_errs(1));
    end
  endtask

  task automatic test_boundary();
    clear_mon();
    issue_cmd(55);
    feed(55, 1, 1'b0);
    checks++;
    if (in_ready !== 1'b0 || active !== 1'b1) begin
      errors++;
      $display("[TB] FAIL len_limit: in_ready %b active %b, required 0 1", in_ready, active);
    end
    in_valid = 1'b1;
    in_data  = 8'hEE;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    wait_idle();
    checks++;
    if (cap_cnt !== 64 || cap_data[55] !== 8'h80 || cap_data[62] !== 8'h01 || cap_data[63] !== 8'hB8) begin
      errors++;
      $display("[TB] FAIL len55_pad: bytes %0d b55 %h b62 %h b63 %h, required 64 80 01 B8",
               cap_cnt, cap_data[55], cap_data[62], cap_data[63]);
    end
    checks++;
    if (stream_errs(55, 1) !== 0 || flag_errs(1) !== 0 || dut.u_fifo.empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL len55_stream: byte_errs %0d flag_errs %0d fifo_empty %b, required 0 0 1",
               stream_errs(55, 1), flag_errs(1), dut.u_fifo.empty);
    end
    run_msg(64, 1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (cap_cnt !== 128 || cap_data[64] !== 8'h80 || cap_data[126] !== 8'h02 || cap_data[127] !== 8'h00) begin
      errors++;
      $display("[TB] FAIL len64_pad: bytes %0d b64 %h b126 %h b127 %h, required 128 80 02 00",
               cap_cnt, cap_data[64], cap_data[126], cap_data[127]);
    end
    checks++;
    if (stream_errs(64, 1) !== 0 || flag_errs(2) !== 0) begin
      errors++;
      $display("[TB] FAIL len64_stream: byte_errs %0d flag_errs %0d, required 0",
               stream_errs(64, 1), flag_errs(2));
    end
  endtask

  task automatic test_stall();
    run_msg(56, 0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (run_cnt !== 2 || run_errs() !== 0) begin
      errors++;
      $display("[TB] FAIL stall_bursts: runs %0d bad_runs %0d, required 2 0", run_cnt, run_errs());
    end
    checks++;
    if (gaps[1] !== 11) begin
      errors++;
      $display("[TB] FAIL stall_gap: got %0d idle cycles, required 11", gaps[1]);
    end
    checks++;
    if (stream_errs(56, 0) !== 0 || flag_errs(2) !== 0 || viol !== 0) begin
      errors++;
      $display("[TB] FAIL stall_stream: byte_errs %0d flag_errs %0d leaks %0d, required 0",
               stream_errs(56, 0), flag_errs(2), viol);
    end
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    clear_mon();
    issue_cmd(56);
    feed(56, 0, 1'b0);
    while (!core_write_enable && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    repeat (30) @(negedge clk);
    checks++;
    if (core_write_enable !== 1'b1 || core_data !== 8'h30) begin
      errors++;
      $display("[TB] FAIL mid_block_before_reset: we %b data %h, required 1 30", core_write_enable, core_data);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, in_ready, core_write_enable, core_first_block, core_last_block, active, msg_done} !== 7'b0
        || core_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL mid_reset_outputs: we %b data %h active %b cmd_ready %b, required all 0",
               core_write_enable, core_data, active, cmd_ready);
    end
    checks++;
    if (dut.u_fifo.empty !== 1'b1 || dut.u_fifo.count !== 7'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset_fifo: empty %b count %0d, required 1 0", dut.u_fifo.empty, dut.u_fifo.count);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || active !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset_release: cmd_ready %b active %b, required 1 0", cmd_ready, active);
    end
    run_msg(56, 0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (cap_cnt !== 128 || stream_errs(56, 0) !== 0 || flag_errs(2) !== 0) begin
      errors++;
      $display("[TB] FAIL rerun_stream: bytes %0d byte_errs %0d flag_errs %0d, required 128 0 0",
               cap_cnt, stream_errs(56, 0), flag_errs(2));
    end
  endtask

  initial begin
    reset             = 1'b0;
    cmd_valid         = 1'b0;
    cmd_len           = '0;
    in_valid          = 1'b0;
    in_data           = 8'h00;
    core_busy         = 1'b0;
    core_output_valid = 1'b0;
    test_reset();
    test_two_block();
    test_overlap();
    test_empty();
    test_boundary();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha_msg_sequencer.md
Name: sha_msg_sequencer

Overview:
- Front-end controller for the SHA-256 core (`top`).
- Accepts a message-length command and a byte stream, then performs SHA-256 padding: 0x80, zero fill, and a 64-bit big-endian bit length.
- Feeds the core one contiguous 64-byte block at a time, with correct first/last flags and idle gaps, and waits for core busy.
- Buffers input in a byte FIFO so upstream stalls never break a block.

Parameters:
- LEN_W, 32, width of message byte-length; bit length = {len,3'b000} zero-extended to 64.
- FIFO_DEPTH, 64, byte FIFO depth; power of two, at least 64.

Ports:
- clk  input  1  clock, all logic on posedge
- reset  input  1  asynchronous, active-low reset
- cmd_valid  input  1  new message command
- cmd_len  input  LEN_W  message length in bytes; 0 is legal
- cmd_ready  output  1  high only in IDLE
- in_valid  input  1  message byte valid
- in_data  input  8  message byte
- in_ready  output  1  byte accepted when in_valid & in_ready
- core_data  output  8  byte to core
- core_write_enable  output  1  byte strobe to core
- core_first_block  output  1  high with byte 0 of block 0 only
- core_last_block  output  1  high with byte 0 of final block only
- core_busy  input  1  core cannot accept a new block
- core_output_valid  input  1  core digest nibbles streaming
- msg_done  output  1  one-cycle pulse on falling edge of core_output_valid
- active  output  1  high from command accept until the final block's last byte

Behaviour:
- Reset (reset=0, async): all outputs 0 except cmd_ready=1 once released; FIFO emptied; state IDLE; length and counters cleared.
- Command: the handshake on cmd_valid & cmd_ready latches cmd_len as L and computes nblocks = floor((L+8)/64)+1. Then IDLE -> LAUNCH.
- in_ready = FIFO not full AND accepted_bytes < L. Extra bytes are never accepted.
- Stream index i runs over 0..nblocks*64-1:
  - i<L: FIFO byte.
  - i==L: 0x80.
  - i >= nblocks*64-8: byte (i - (nblocks*64-8)) of the 64-bit bit length, MSB first.
  - else: 0x00.
- LAUNCH (core_write_enable=0):
  - Block k needs need_k = min(64, max(0, L-64k)) message bytes in the FIFO.
  - Go to SEND when FIFO count >= need_k AND core_busy==0, both sampled this cycle.
  - Otherwise hold LAUNCH.
- SEND: 64 consecutive cycles with core_write_enable=1 and one byte per cycle. There are no bubbles inside a block; FIFO pops occur only for i<L.
  - core_first_block=1 on byte 0 when k==0.
  - core_last_block=1 on byte 0 when k==nblocks-1.
  - A single-block message asserts both flags together.
- After byte 63:
  - If more blocks remain: GAP for 1 cycle (we=0), then LAUNCH.
  - Else: active=0, go to IDLE.
- Minimum spacing between blocks is 2 idle cycles: GAP + LAUNCH.
- All flags and core_data are 0 whenever core_write_enable=0.
- msg_done is driven from a registered copy of core_output_valid. It is independent of state, so a new message may be sequenced while a digest is still draining.
- cmd_valid outside IDLE is ignored (cmd_ready=0).
- Reset mid-block: immediate return to reset values. The core sees core_write_enable drop and must itself be reset.
- Length arithmetic is at LEN_W+4 bits with no overflow for any LEN_W value.

Decomposition:
- Package sha_pkg holds:
  - BLOCK_BYTES=64 and LEN_BYTES=8
  - PAD_BYTE=8'h80
  - state enum {IDLE, LAUNCH, SEND, GAP}
- Sub-module sha_byte_fifo: sync FIFO with parameterised depth, push/pop/count/full/empty, async active-low reset.

Test Plan:
1. L=56, 56 bytes of 0x30 sent back-to-back.
   - Expect 2 blocks.
   - Byte 56 = 0x80; bytes 120..127 = 00 00 00 00 00 00 01 C0.
   - core_first_block on byte 0; core_last_block on byte 64.
   - Core digest = bd03ac14...857ffc18; msg_done pulses once.
2. L=120 of 0x30, issued while the test 1 digest is still streaming.
   - Expect 3 blocks; byte 120 = 0x80; length bytes end 03 C0.
   - Digest = 09719c55...8c7eedab.
3. L=0.
   - Expect 1 block: byte 0 = 0x80, all other bytes 0x00.
   - Both flags high on byte 0.
4. L=55.
   - Expect 1 block: 0x80 at byte 55; bytes 56..63 = 00 00 00 00 00 00 01 B8.
   - L=64: 2 blocks, 0x80 at byte 64, length 02 00.
5. L=56 with in_valid toggled every other cycle, and core_busy held high for 10 cycles at the second LAUNCH.
   - core_write_enable stays high for exactly 64 consecutive cycles per block.
   - LAUNCH holds while core_busy is high.
   - Byte stream is identical to test 1.
6. Assert reset low during byte 30 of block 0 of test 1.
   - All outputs go to 0 immediately and the FIFO is empty.
   - After release, cmd_ready=1, and a fresh test-1 run produces the correct digest.
